otter_lsu: RTL and testbench
============================

OTTER_LSU -- requirements
Module: otter_lsu

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles without mem_ack before an access is aborted.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 ex_valid  input  1  the EX/MEM register holds a valid instruction.
REQ-005 ex_mem_read / ex_mem_write  input  1 each  load / store request.
REQ-006 ex_funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ex_addr  input  32  byte address (ALU result).
REQ-008 ex_wdata / ex_rd  input  32 / 5  store data / load destination register.
REQ-009 lsu_busy  output  1  stall to upstream stages.
REQ-010 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-011 mem_addr, mem_wdata, mem_be  output  32, 32, 4  word-aligned address, lane data, byte enables.
REQ-012 mem_ack, mem_rdata  input  1, 32  bus completion and read word.
REQ-013 wb_valid, wb_rd, wb_data, err  output  1, 5, 32, 1  load result to writeback; error pulse.

Function
REQ-014 FSM states SHALL be IDLE and WAIT; lsu_busy = (state == WAIT) | accept.
REQ-015 Accept SHALL occur in IDLE when ex_valid & (ex_mem_read | ex_mem_write).
REQ-016 If both read and write are asserted, the access SHALL be treated as a load.
REQ-017 On accept, address, byte enables, lane data, type and rd SHALL be registered, and the FSM SHALL go to WAIT.
REQ-018 In WAIT, mem_req SHALL be 1 and all bus outputs SHALL be held stable until mem_ack.
REQ-019 mem_ack in WAIT SHALL return the FSM to IDLE; a new accept is not possible in that same cycle.
REQ-020 mem_ack in IDLE SHALL be ignored.
REQ-021 mem_addr SHALL be {addr[31:2], 2'b00}.
REQ-022 Byte enables: B = 0001 << addr[1:0]; H = 0011 << (2*addr[1]); W = 1111.
REQ-023 Store data: SB SHALL replicate byte[7:0] into all 4 lanes; SH SHALL replicate half[15:0] into both halves; SW SHALL pass the word through.
REQ-024 Load data: the selected lane SHALL be shifted to bit 0, then sign-extended (B, H) or zero-extended (BU, HU); W passes through.
REQ-025 funct3 values 011, 110 and 111 SHALL be treated as W.
REQ-026 Load completion: wb_valid SHALL pulse 1 cycle, the cycle after mem_ack, carrying wb_rd and the formatted data.
REQ-027 Store completion: no wb_valid SHALL be produced.
REQ-028 Load-to-use latency SHALL be accept + 1 + (cycles to mem_ack) + 1.
REQ-029 wb_data SHALL hold its value until the next load completes.
REQ-030 Timeout: TIMEOUT consecutive WAIT cycles without mem_ack SHALL drop mem_req, pulse err for 1 cycle, and return the FSM to IDLE.
REQ-031 A timed-out load SHALL pulse wb_valid with wb_data = 0.

Reset
REQ-032 RST SHALL immediately force: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, wb_valid 0, wb_rd 0, wb_data 0, err 0, lsu_busy 0, timeout counter 0.
REQ-033 RST asserted during WAIT SHALL abandon the access; a late mem_ack after release SHALL be ignored.

Configuration
REQ-034 Macro OTTER_LSU_MISALIGN_CHK_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, SHALL NOT issue mem_req.
REQ-035 Misaligned access, macro defined: err SHALL pulse the cycle after accept, a load SHALL pulse wb_valid with wb_data = 0, and the FSM SHALL remain in IDLE.
REQ-036 Macro undefined: misaligned accesses SHALL proceed with H using addr[1] only and W ignoring addr[1:0]; err SHALL be raised only by timeout.

Verification
REQ-037 SB addr 0x103, wdata 0x000000A5 -> mem_addr 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5, mem_we 1, no wb_valid.
REQ-038 LB addr 0x201, rdata 0x00008000 acked after 3 WAIT cycles -> wb_valid 1 cycle after ack, wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LH addr 0x202, rdata 0x8001_1234 -> wb_data 0xFFFF8001; lsu_busy high from accept through the ack cycle.
REQ-040 LW with no ack, TIMEOUT=16 -> after 16 WAIT cycles: err pulse, wb_valid with 0, state IDLE.
REQ-041 RST pulsed mid-WAIT, then mem_ack -> mem_req 0 immediately, no wb_valid, no err.
REQ-042 LW addr 0x102 with OTTER_LSU_MISALIGN_CHK_EN defined -> no mem_req, err pulse, wb_data 0; macro undefined -> mem_addr 0x100, normal load.

Source files
------------

// File: rtl/otter_lsu_if.sv
// otter_lsu_if: word-oriented data bus between the OTTER load/store unit and memory.
// Ports: master drives mem_req/mem_we/mem_addr/mem_wdata/mem_be and receives mem_ack/mem_rdata;
//        slave is the memory side of the same signals.
interface otter_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/otter_lsu.sv
// otter_lsu: load/store unit for the OTTER MEM stage. Registers one access on accept, holds the
// bus request until mem_ack or TIMEOUT WAIT cycles, and returns formatted load data one cycle later.
// Ports: CLK/RST (async, active-high); ex_*_i request from EX/MEM; lsu_busy_o stall; bus (master
//        modport of otter_lsu_if); wb_valid_o/wb_rd_o/wb_data_o load writeback; err_o error pulse.
// Optional: define OTTER_LSU_MISALIGN_CHK_EN to reject misaligned H/W accesses without a bus request.
module otter_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ex_valid_i,
  input  logic               ex_mem_read_i,
  input  logic               ex_mem_write_i,
  input  logic [2:0]         ex_funct3_i,
  input  logic [31:0]        ex_addr_i,
  input  logic [31:0]        ex_wdata_i,
  input  logic [4:0]         ex_rd_i,
  output logic               lsu_busy_o,
  otter_lsu_if.master        bus,
  output logic               wb_valid_o,
  output logic [4:0]         wb_rd_o,
  output logic [31:0]        wb_data_o,
  output logic               err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [4:0]    rd_q, rd_d;
  logic          load_q, load_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          err_q, err_d;

  logic          accept;
  logic          misalign;
  logic          is_load;
  logic [1:0]    ex_size;
  logic [3:0]    ex_be;
  logic [31:0]   ex_lane_wdata;
  logic [31:0]   rd_shifted;
  logic [15:0]   rd_half;
  logic [31:0]   load_fmt;

  // Gating with RST keeps the stall low while reset is asserted, even if EX is still presenting work.
  assign accept  = ~RST & (state_q == IDLE) & ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
  // A simultaneous read and write is resolved as a load.
  assign is_load = ex_mem_read_i;

  // Unlisted funct3 encodings (011, 110, 111) fall through to word.
  always_comb begin
    case (ex_funct3_i)
      3'b000, 3'b100: ex_size = SZ_B;
      3'b001, 3'b101: ex_size = SZ_H;
      default:        ex_size = SZ_W;
    endcase
  end

  always_comb begin
    case (ex_size)
      SZ_B: begin
        ex_be         = 4'b0001 << ex_addr_i[1:0];
        ex_lane_wdata = {4{ex_wdata_i[7:0]}};
      end
      SZ_H: begin
        ex_be         = ex_addr_i[1] ? 4'b1100 : 4'b0011;
        ex_lane_wdata = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        ex_be         = 4'b1111;
        ex_lane_wdata = ex_wdata_i;
      end
    endcase
  end

`ifdef OTTER_LSU_MISALIGN_CHK_EN
  assign misalign = ((ex_size == SZ_H) & ex_addr_i[0]) |
                    ((ex_size == SZ_W) & (ex_addr_i[1:0] != 2'b00));
`else
  // Without the check, H ignores addr[0] and W ignores addr[1:0] through the lane logic above.
  assign misalign = 1'b0;
`endif

  // Bring the addressed lane down to bit 0 before extension.
  assign rd_shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
  assign rd_half    = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (size_q)
      SZ_B:    load_fmt = uns_q ? {24'd0, rd_shifted[7:0]} : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_H:    load_fmt = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_fmt = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    load_d     = load_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_ack seen here is stale and deliberately ignored.
        if (accept) begin
          if (misalign) begin
            err_d = 1'b1;
            if (is_load) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd_i;
              wb_data_d  = 32'd0;
            end
          end else begin
            state_d = WAIT;
            addr_d  = ex_addr_i;
            be_d    = ex_be;
            wdata_d = ex_lane_wdata;
            we_d    = ~is_load;
            size_d  = ex_size;
            uns_d   = ex_funct3_i[2];
            rd_d    = ex_rd_i;
            load_d  = is_load;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (load_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_fmt;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT-th WAIT cycle without an ack: abandon the access.
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (load_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = 32'd0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_W;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      load_q     <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  // Bus fields come straight from registers loaded only on accept, so they stay stable through WAIT.
  assign bus.mem_req   = (state_q == WAIT);
  assign bus.mem_we    = we_q & (state_q == WAIT);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  assign lsu_busy_o = (state_q == WAIT) | accept;
  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_otter_lsu.sv
// tb_otter_lsu: directed bench for otter_lsu; loads push expected writebacks to a queue that a
// negedge monitor pops and compares. Bus responses are driven directly from the stimulus sequence.
module tb_otter_lsu;
  logic        CLK;
  logic        RST;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, wb_valid, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  otter_lsu_if bus ();

  otter_lsu #(.TIMEOUT(16)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ex_valid_i     (ex_valid),
    .ex_mem_read_i  (ex_mem_read),
    .ex_mem_write_i (ex_mem_write),
    .ex_funct3_i    (ex_funct3),
    .ex_addr_i      (ex_addr),
    .ex_wdata_i     (ex_wdata),
    .ex_rd_i        (ex_rd),
    .lsu_busy_o     (lsu_busy),
    .bus            (bus),
    .wb_valid_o     (wb_valid),
    .wb_rd_o        (wb_rd),
    .wb_data_o      (wb_data),
    .err_o          (err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  wb_seen  = 0;
  int  err_seen = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Writeback / error monitor.
  always @(negedge CLK) begin
    wb_t e;
    if (wb_valid === 1'b1) begin
      wb_seen++;
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", wb_data, e.data);
      end
    end
    if (err === 1'b1) err_seen++;
  end

  // Drives one access through accept, 'waits' ack-less WAIT cycles, then an ack carrying rdata.
  task automatic access(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_wb);
    int wb0, er0;
    wb0 = wb_seen;
    er0 = err_seen;
    @(negedge CLK);
    ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    if (rd_en) exp_q.push_back('{rd, e_wb});
    #1;
    chk({tag, "_busy_acc"}, 32'(lsu_busy), 32'd1);
    chk({tag, "_req_idle"}, 32'(bus.mem_req), 32'd0);
    @(negedge CLK);
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_addr = $urandom; ex_wdata = $urandom; ex_funct3 = 3'($urandom);
    #1;
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_addr"}, bus.mem_addr, e_addr);
    chk({tag, "_be"}, 32'(bus.mem_be), 32'(e_be));
    chk({tag, "_we"}, 32'(bus.mem_we), 32'(wr_en & ~rd_en));
    if (!rd_en) chk({tag, "_wdata"}, bus.mem_wdata, e_wd);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      #1;
      chk({tag, "_hold_addr"}, bus.mem_addr, e_addr);
      chk({tag, "_hold_busy"}, 32'(lsu_busy), 32'd1);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    chk({tag, "_busy_ack"}, 32'(lsu_busy), 32'd1);
    @(negedge CLK);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    #1;
    chk({tag, "_wb_lat"}, 32'(wb_valid), 32'(rd_en));
    chk({tag, "_req_done"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_busy_done"}, 32'(lsu_busy), 32'd0);
    @(negedge CLK);
    #1;
    chk({tag, "_wb_count"}, 32'(wb_seen - wb0), 32'(rd_en));
    chk({tag, "_no_err"}, 32'(err_seen - er0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb0, er0;
    RST = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    #12;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Loads: signed/unsigned byte and half, word, aliased word encodings.
    access("lb",  1, 0, 3'b000, 32'h201, 32'h0, 5'd5, 32'h0000_8000, 3, 32'h200, 4'b0010, 32'h0, 32'hFFFF_FF80);
    // Store must leave the previous load result in wb_data.
    access("sb",  0, 1, 3'b000, 32'h103, 32'hA5, 5'd0, 32'h0, 1, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    chk("wb_hold", wb_data, 32'hFFFF_FF80);
    access("lbu", 1, 0, 3'b100, 32'h201, 32'h0, 5'd6, 32'h0000_8000, 3, 32'h200, 4'b0010, 32'h0, 32'h0000_0080);
    access("lh",  1, 0, 3'b001, 32'h202, 32'h0, 5'd7, 32'h8001_1234, 2, 32'h200, 4'b1100, 32'h0, 32'hFFFF_8001);
    access("lhu", 1, 0, 3'b101, 32'h200, 32'h0, 5'd8, 32'h1234_ABCD, 0, 32'h200, 4'b0011, 32'h0, 32'h0000_ABCD);
    access("lw",  1, 0, 3'b010, 32'h300, 32'h0, 5'd9, 32'hDEAD_BEEF, 1, 32'h300, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    access("lb3", 1, 0, 3'b000, 32'h203, 32'h0, 5'd10, 32'h7F00_0000, 0, 32'h200, 4'b1000, 32'h0, 32'h0000_007F);
    access("sh",  0, 1, 3'b001, 32'h102, 32'h1234_BEEF, 5'd0, 32'h0, 2, 32'h100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    access("sw",  0, 1, 3'b010, 32'h104, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 32'h104, 4'b1111, 32'hCAFE_F00D, 32'h0);
    access("f011", 1, 0, 3'b011, 32'h010, 32'h0, 5'd11, 32'h8765_4321, 1, 32'h010, 4'b1111, 32'h0, 32'h8765_4321);
    // Read and write together resolve as a load (no write strobe, writeback produced).
    access("rw111", 1, 1, 3'b111, 32'h020, 32'h5555_5555, 5'd12, 32'h0BAD_F00D, 0, 32'h020, 4'b1111, 32'h0, 32'h0BAD_F00D);

    // Timeout: no ack for 16 WAIT cycles.
    er0 = err_seen;
    @(negedge CLK);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h400; ex_rd = 5'd13;
    exp_q.push_back('{5'd13, 32'h0});
    @(negedge CLK);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    #1;
    chk("to_req_first", 32'(bus.mem_req), 32'd1);
    repeat (15) @(negedge CLK);
    #1;
    chk("to_req_last", 32'(bus.mem_req), 32'd1);
    chk("to_err_early", 32'(err), 32'd0);
    @(negedge CLK);
    #1;
    chk("to_req_drop", 32'(bus.mem_req), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_wb_data", wb_data, 32'd0);
    chk("to_busy", 32'(lsu_busy), 32'd0);
    @(negedge CLK);
    #1;
    chk("to_err_pulse", 32'(err), 32'd0);
    chk("to_err_count", 32'(err_seen - er0), 32'd1);

    // Reset in the middle of WAIT, then a late ack.
    wb0 = wb_seen;
    er0 = err_seen;
    @(negedge CLK);
    ex_valid = 1'b1; ex_mem_read = 1'b1;
    ex_funct3 = 3'b010; ex_addr = 32'h500; ex_rd = 5'd3;
    @(negedge CLK);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    @(negedge CLK);
    #1;
    chk("rw_req_before", 32'(bus.mem_req), 32'd1);
    RST = 1'b1;
    #1;
    chk("rw_req", 32'(bus.mem_req), 32'd0);
    chk("rw_busy", 32'(lsu_busy), 32'd0);
    chk("rw_addr", bus.mem_addr, 32'd0);
    chk("rw_be", 32'(bus.mem_be), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    #1;
    chk("rw_req_after", 32'(bus.mem_req), 32'd0);
    @(negedge CLK);
    #1;
    chk("rw_no_wb", 32'(wb_seen - wb0), 32'd0);
    chk("rw_no_err", 32'(err_seen - er0), 32'd0);

    // Misaligned word load.
`ifdef OTTER_LSU_MISALIGN_CHK_EN
    er0 = err_seen;
    @(negedge CLK);
    ex_valid = 1'b1; ex_mem_read = 1'b1;
    ex_funct3 = 3'b010; ex_addr = 32'h102; ex_rd = 5'd14;
    exp_q.push_back('{5'd14, 32'h0});
    #1;
    chk("mis_busy", 32'(lsu_busy), 32'd1);
    @(negedge CLK);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    #1;
    chk("mis_no_req", 32'(bus.mem_req), 32'd0);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_wb_data", wb_data, 32'd0);
    @(negedge CLK);
    #1;
    chk("mis_err_pulse", 32'(err), 32'd0);
    chk("mis_idle", 32'(bus.mem_req), 32'd0);
    chk("mis_err_count", 32'(err_seen - er0), 32'd1);
`else
    access("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 5'd14, 32'h1122_3344, 1, 32'h100, 4'b1111, 32'h0, 32'h1122_3344);
    access("lh_mis", 1, 0, 3'b001, 32'h103, 32'h0, 5'd15, 32'hC0DE_0001, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF_C0DE);
`endif

    repeat (2) @(negedge CLK);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
